// File: rtl/sha3_miner_pkg.sv
// Shared constants and state encoding for the SHA3 miner chunk scheduler.
package sha3_miner_pkg;

   localparam int unsigned DRAIN_DEF  = 16;
   localparam int unsigned SETTLE_DEF = 4;
   localparam logic [7:0]  PADF_DEF   = 8'h06;
   localparam logic [7:0]  PADL_DEF   = 8'h80;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOAD      = 3'd1,
      ST_SETTLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_DONE      = 3'd4,
      ST_EXHAUSTED = 3'd5
   } state_t;

endpackage

// File: rtl/sha3_miner_sched.sv
// Chunk scheduler for an external SHA3-256 miner: hands out nonce chunks,
// double-buffers the header and latches the first reported solution.
module sha3_miner_sched
   import sha3_miner_pkg::*;
#(
   parameter int unsigned DRAIN  = DRAIN_DEF,
   parameter int unsigned SETTLE = SETTLE_DEF,
   parameter logic [7:0]  PADF   = PADF_DEF,
   parameter logic [7:0]  PADL   = PADL_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           go,
   input  logic           abort,
   input  logic [63:0]    base_nonce,
   input  logic [31:0]    chunk_len,
   input  logic [15:0]    max_chunks,
   input  logic           test,
   input  logic [255:0]   hdr_in,
   input  logic           hdr_wr,
   output logic [17:0]    m_control,
   output logic [63:0]    m_start_nonce,
   output logic [255:0]   m_header,
   input  logic [63:0]    m_solution,
   input  logic           m_irq,
   output logic           busy,
   output logic           found,
   output logic [63:0]    result_nonce,
   output logic [15:0]    chunks_done,
   output logic           exhausted,
   output state_t         state_dbg
);

   localparam logic [7:0]  SETTLE_INIT = 8'(SETTLE - 1);
   localparam logic [64:0] DRAIN_EXT   = 65'(DRAIN);

   state_t         state, state_next;
   logic [7:0]     settle_cnt;
   logic [63:0]    cur_start;
   logic [31:0]    len_r;
   logic [15:0]    max_r;
   logic [255:0]   hdr_shadow;
   logic           hdr_pending;

   logic [64:0]    span;
   logic [64:0]    limit;
   logic           span_done;
   logic           last_chunk;
   logic           take_go;
   logic           do_load;
   logic           hit;
   logic           end_chunk;

   // Distance is taken modulo 2^64 so a chunk that straddles the nonce wrap
   // still measures correctly; the compare is one bit wider than the operands.
   assign span       = {1'b0, m_solution - cur_start};
   assign limit      = {33'd0, len_r} + DRAIN_EXT;
   assign span_done  = (span >= limit);
   assign last_chunk = (max_r != 16'd0) && (({1'b0, chunks_done} + 17'd1) == {1'b0, max_r});

   assign take_go   = go && !abort &&
                      ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_EXHAUSTED));
   assign do_load   = (state == ST_LOAD) && !abort;
   assign hit       = (state == ST_RUN) && m_irq && !abort;
   assign end_chunk = (state == ST_RUN) && !m_irq && span_done && !abort;

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE, ST_DONE, ST_EXHAUSTED: if (go) state_next = ST_LOAD;
         ST_LOAD:                        state_next = ST_SETTLE;
         ST_SETTLE:                      if (settle_cnt == 8'd0) state_next = ST_RUN;
         ST_RUN: begin
            if (m_irq)          state_next = ST_DONE;
            else if (span_done) state_next = last_chunk ? ST_EXHAUSTED : ST_LOAD;
         end
         default:                        state_next = ST_IDLE;
      endcase
      if (abort) state_next = ST_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settle_cnt    <= 8'd0;
         cur_start     <= 64'd0;
         len_r         <= 32'd0;
         max_r         <= 16'd0;
         m_start_nonce <= 64'd0;
         m_header      <= 256'd0;
         hdr_shadow    <= 256'd0;
         hdr_pending   <= 1'b0;
         result_nonce  <= 64'd0;
         chunks_done   <= 16'd0;
      end else begin
         if (take_go) begin
            cur_start   <= base_nonce;
            len_r       <= chunk_len;
            max_r       <= max_chunks;
            chunks_done <= 16'd0;
         end
         if (do_load) begin
            m_start_nonce <= cur_start;
            settle_cnt    <= SETTLE_INIT;
            if (hdr_pending) begin
               m_header    <= hdr_shadow;
               hdr_pending <= 1'b0;
            end
         end
         if ((state == ST_SETTLE) && (settle_cnt != 8'd0)) settle_cnt <= settle_cnt - 8'd1;
         if (hit) result_nonce <= m_solution;
         if (end_chunk) begin
            cur_start <= cur_start + {32'd0, len_r};
            if (chunks_done != 16'hFFFF) chunks_done <= chunks_done + 16'd1;
         end
         // A host write always wins over the LOAD consuming the previous value.
         if (hdr_wr) begin
            hdr_shadow  <= hdr_in;
            hdr_pending <= 1'b1;
         end
      end
   end

   assign m_control = {PADF, PADL, test, (state == ST_RUN)};
   assign busy      = (state == ST_LOAD) || (state == ST_SETTLE) || (state == ST_RUN);
   assign found     = (state == ST_DONE);
   assign exhausted = (state == ST_EXHAUSTED);
   assign state_dbg = state;

endmodule
